// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl
//   Sequencer for a left-to-right square-and-multiply modular exponentiation
//   built around an external Montgomery multiplier.
//     acc = one_m
//     for i = EBITS-1 downto 0:
//       acc = MM(acc, acc)
//       if exponent[i]: acc = MM(acc, base)
//     result = MM(acc, 1)      (converts back out of the Montgomery domain)
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start           request a new exponentiation (only looked at in IDLE)
//   base, exponent  operands; base is already in Montgomery form
//   one_m           Montgomery form of 1 (R mod N), the initial accumulator
//   mm_x, mm_y      operands presented to the multiplier
//   mm_start        one-cycle request pulse to the multiplier
//   mm_z, mm_done   multiplier product and its one-cycle completion pulse
//   result          final product, held until the next completion
//   done            one-cycle completion pulse
//   busy            high from start acceptance through the done cycle
//   dbg_state       current FSM state encoding (debug visibility)
//
// Handshake: the caller raises start while busy=0; the request is taken on
// that clock edge and everything on base/exponent/one_m is copied then, so
// the inputs are free to change afterwards. Toward the multiplier, mm_x/mm_y
// are valid in the cycle mm_start is high and stay put until the matching
// mm_done; exactly one request is outstanding at any time, and mm_done is
// only honoured while a request is outstanding (the *_WAIT states).
module mod_exp_ctrl #(
    parameter int WIDTH = 192,
    parameter int EBITS = 192
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EBITS-1:0] exponent,
    input  logic [WIDTH-1:0] one_m,
    output logic [WIDTH-1:0] mm_x,
    output logic [WIDTH-1:0] mm_y,
    output logic             mm_start,
    input  logic [WIDTH-1:0] mm_z,
    input  logic             mm_done,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam int             CW      = (EBITS > 1) ? $clog2(EBITS) : 1;
    localparam logic [CW-1:0]  CNT_TOP = CW'(EBITS - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SQR_ISSUE = 3'd1,
        SQR_WAIT  = 3'd2,
        MUL_ISSUE = 3'd3,
        MUL_WAIT  = 3'd4,
        FIX_ISSUE = 3'd5,
        FIX_WAIT  = 3'd6,
        DONE      = 3'd7
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base_r;
    logic [EBITS-1:0] exp_r;
    logic [CW-1:0]    cnt;

    assign dbg_state = state;

    // Operands for the next request are loaded on the same edge that enters
    // the *_ISSUE state, straight from the value being written into acc
    // (mm_z on a completion, one_m on start). That way mm_x/mm_y are already
    // valid in the issue cycle without an extra pipeline stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            base_r   <= '0;
            exp_r    <= '0;
            cnt      <= '0;
            result   <= '0;
            mm_x     <= '0;
            mm_y     <= '0;
            mm_start <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            mm_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_r   <= base;
                        exp_r    <= exponent;
                        acc      <= one_m;
                        cnt      <= CNT_TOP;
                        mm_x     <= one_m;
                        mm_y     <= one_m;
                        mm_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SQR_ISSUE;
                    end
                end
                SQR_ISSUE: state <= SQR_WAIT;
                SQR_WAIT: begin
                    if (mm_done) begin
                        acc      <= mm_z;
                        mm_x     <= mm_z;
                        mm_start <= 1'b1;
                        if (exp_r[cnt]) begin
                            // Bit set: multiply in the base before moving on.
                            mm_y  <= base_r;
                            state <= MUL_ISSUE;
                        end else if (cnt == '0) begin
                            mm_y  <= ONE;
                            state <= FIX_ISSUE;
                        end else begin
                            mm_y  <= mm_z;
                            cnt   <= cnt - CW'(1);
                            state <= SQR_ISSUE;
                        end
                    end
                end
                MUL_ISSUE: state <= MUL_WAIT;
                MUL_WAIT: begin
                    if (mm_done) begin
                        acc      <= mm_z;
                        mm_x     <= mm_z;
                        mm_start <= 1'b1;
                        if (cnt == '0) begin
                            mm_y  <= ONE;
                            state <= FIX_ISSUE;
                        end else begin
                            mm_y  <= mm_z;
                            cnt   <= cnt - CW'(1);
                            state <= SQR_ISSUE;
                        end
                    end
                end
                FIX_ISSUE: state <= FIX_WAIT;
                FIX_WAIT: begin
                    if (mm_done) begin
                        // result and done are registered together so the
                        // product is visible in the same cycle as the pulse.
                        acc    <= mm_z;
                        result <= mm_z;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl. The multiplier is a behavioural stand-in computing
// MM(a,b) = a*b mod 7 with a fixed latency, and one_m = 1, so the expected
// result is simply base^exponent mod 7.
module tb_mod_exp_ctrl;

    localparam int WIDTH = 192;
    localparam int EBITS = 192;
    localparam int LAT   = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] base;
    logic [EBITS-1:0] exponent;
    logic [WIDTH-1:0] one_m;
    logic [WIDTH-1:0] mm_x;
    logic [WIDTH-1:0] mm_y;
    logic             mm_start;
    logic [WIDTH-1:0] mm_z    = '0;
    logic             mm_done = 1'b0;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic [2:0]       dbg_state;

    mod_exp_ctrl #(.WIDTH(WIDTH), .EBITS(EBITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .exponent  (exponent),
        .one_m     (one_m),
        .mm_x      (mm_x),
        .mm_y      (mm_y),
        .mm_start  (mm_start),
        .mm_z      (mm_z),
        .mm_done   (mm_done),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- multiplier model ----------------
    function automatic logic [WIDTH-1:0] mm_model(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] am;
        logic [WIDTH-1:0] bm;
        am = a % 7;
        bm = b % 7;
        return (am * bm) % 7;
    endfunction

    logic [WIDTH-1:0] lat_x = '0;
    logic [WIDTH-1:0] lat_y = '0;
    int  pend_cnt  = 0;
    bit  pending   = 0;
    bit  orphan    = 0;
    int  pulses    = 0;
    int  proto_bad = 0;

    // Inputs to the DUT change on the falling edge, well away from sampling.
    always @(negedge clk) begin
        mm_done = 1'b0;
        if (reset === 1'b1) orphan = 1;
        if (pending) begin
            if (!orphan && (mm_x !== lat_x || mm_y !== lat_y)) proto_bad++;
            pend_cnt--;
            if (pend_cnt == 0) begin
                mm_done = 1'b1;
                mm_z    = mm_model(lat_x, lat_y);
                pending = 0;
            end
        end
        if (mm_start === 1'b1) begin
            if (pending) proto_bad++;
            pending  = 1;
            pend_cnt = LAT;
            lat_x    = mm_x;
            lat_y    = mm_y;
            pulses++;
        end
        if (!pending && reset !== 1'b1) orphan = 0;
    end

    // ---------------- reference model ----------------
    // base^e mod 7 via Fermat (b^6 = 1 for b != 0 mod 7).
    function automatic logic [WIDTH-1:0] exp_ref(input logic [WIDTH-1:0] b,
                                                 input logic [EBITS-1:0] e);
        logic [WIDTH-1:0] bm;
        logic [WIDTH-1:0] r;
        int k;
        if (e == '0) return WIDTH'(1);
        bm = b % 7;
        if (bm == '0) return '0;
        k = int'(e % 6);
        if (k == 0) k = 6;
        r = WIDTH'(1);
        for (int i = 0; i < k; i++) r = (r * bm) % 7;
        return r;
    endfunction

    function automatic int exp_cycles(input logic [EBITS-1:0] e);
        return 1 + (EBITS + $countones(e) + 1) * (LAT + 1);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [WIDTH-1:0] b, input logic [EBITS-1:0] e,
                            output int s);
        @(negedge clk);
        base      = b;
        exponent  = e;
        one_m     = WIDTH'(1);
        start     = 1'b1;
        pulses    = 0;
        proto_bad = 0;
        s         = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done and checks the completed run. repulse_at > 0
    // raises start and scrambles the inputs at that cycle of the run. With
    // chain set, start is raised again in the DONE cycle and left high into
    // the following IDLE cycle (base=2, exponent=0); the caller drops it.
    task automatic wait_done(input string name, input int s,
                             input logic [WIDTH-1:0] exp_res, input int exp_cyc,
                             input int exp_pulses, input int repulse_at,
                             input bit chain);
        int n;
        bit seen;
        int dc;
        n    = 0;
        seen = 0;
        dc   = 0;
        while (!seen && n < 4000) begin
            @(negedge clk);
            n++;
            if (repulse_at > 0 && cyc - s == repulse_at) begin
                start    = 1'b1;
                base     = WIDTH'($urandom_range(0, 6));
                exponent = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                one_m    = WIDTH'($urandom_range(2, 6));
            end else if (repulse_at > 0 && cyc - s == repulse_at + 1) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                seen = 1;
                dc   = cyc - s;
            end
        end
        check({name, " done seen"}, WIDTH'(seen), WIDTH'(1));
        check({name, " done cycle"}, WIDTH'(dc), WIDTH'(exp_cyc));
        check({name, " result"}, result, exp_res);
        check({name, " mm_start pulses"}, WIDTH'(pulses), WIDTH'(exp_pulses));
        check({name, " busy at done"}, WIDTH'(busy), WIDTH'(1));
        check({name, " protocol errors"}, WIDTH'(proto_bad), '0);
        if (chain) begin
            start     = 1'b1;
            base      = WIDTH'(2);
            exponent  = '0;
            one_m     = WIDTH'(1);
            pulses    = 0;
            proto_bad = 0;
        end
        @(negedge clk);
        check({name, " done one cycle"}, WIDTH'(done), '0);
        check({name, " busy after done"}, WIDTH'(busy), '0);
        check({name, " result held"}, result, exp_res);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [WIDTH-1:0] b;
        logic [EBITS-1:0] e;
        logic [WIDTH-1:0] res;
        int               cycles;
        int               npulse;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int s;
        int s2;
        bit seen;
        logic [WIDTH-1:0] rb;
        logic [EBITS-1:0] re;

        vecs[0] = '{WIDTH'(3), EBITS'(5), WIDTH'(5), 1171, 195};
        vecs[1] = '{WIDTH'(2), EBITS'(0), WIDTH'(1), 1159, 193};
        vecs[2] = '{WIDTH'(4), EBITS'(3), WIDTH'(1), 1171, 195};

        reset    = 1'b1;
        start    = 1'b0;
        base     = '0;
        exponent = '0;
        one_m    = WIDTH'(1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset result", result, '0);
        check("reset mm_x", mm_x, '0);
        check("reset mm_y", mm_y, '0);
        check("reset mm_start", WIDTH'(mm_start), '0);
        check("reset done", WIDTH'(done), '0);
        check("reset busy", WIDTH'(busy), '0);
        check("reset state idle", WIDTH'(dbg_state), '0);

        // Directed table.
        for (int i = 0; i < 3; i++) begin
            do_start(vecs[i].b, vecs[i].e, s);
            wait_done($sformatf("vec%0d", i), s, vecs[i].res, vecs[i].cycles,
                      vecs[i].npulse, 0, 1'b0);
        end

        // Start re-pulsed (and inputs scrambled) mid-run: no effect.
        do_start(WIDTH'(3), EBITS'(5), s);
        wait_done("repulse", s, WIDTH'(5), 1171, 195, 100, 1'b0);

        // Reset mid-run: abort with no done; stray mm_done afterwards ignored.
        do_start(WIDTH'(3), EBITS'(5), s);
        while (cyc - s < 400) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check("abort no done", WIDTH'(seen), '0);
        check("abort busy", WIDTH'(busy), '0);
        check("abort state idle", WIDTH'(dbg_state), '0);
        check("abort result cleared", result, '0);
        check("abort mm_start quiet", WIDTH'(mm_start), '0);
        do_start(WIDTH'(4), EBITS'(3), s);
        wait_done("after abort", s, WIDTH'(1), 1171, 195, 0, 1'b0);

        // Start in DONE ignored, start in the following IDLE accepted.
        do_start(WIDTH'(3), EBITS'(5), s);
        wait_done("chain first", s, WIDTH'(5), 1171, 195, 0, 1'b1);
        s2 = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_done("chain second", s2, WIDTH'(1), 1159, 193, 0, 1'b0);

        // Randomized runs against the reference model.
        for (int i = 0; i < 5; i++) begin
            rb = WIDTH'($urandom_range(0, 6));
            re = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (i == 0) re = '1;
            do_start(rb, re, s);
            wait_done($sformatf("rand%0d", i), s, exp_ref(rb, re), exp_cycles(re),
                      EBITS + $countones(re) + 1, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
